spi_register_controller: RTL

Command controller that sits behind the slave SPI receiver in `top` and turns the raw byte stream into register reads and writes. It decodes the first byte of each CS-framed transaction as a command, then writes subsequent bytes into a register bank or supplies register contents as the next transmit byte. Address auto-increments and wraps. The register bank drives the display path and any other consumer in `top`.

---
 rtl/spi_register_controller_if.sv | 26 ++
 rtl/spi_register_controller.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/spi_register_controller_if.sv
// Byte-level bus between the SPI slave receiver and the register command controller.
// The controller uses the slave modport; the receiver/consumer side uses the master modport.
interface spi_register_controller_if #(
  parameter int unsigned REG_COUNT = 8
);
  logic                   CS_i;
  logic [7:0]             RxData_i;
  logic                   RxDone_i;
  logic [7:0]             TxData_o;
  logic [8*REG_COUNT-1:0] Regs_o;
  logic                   WriteStrobe_o;
  logic [2:0]             WriteAddr_o;
  logic                   Busy_o;
  logic                   FrameError_o;
  logic [7:0]             FrameCount_o;

  modport slave (
    input  CS_i, RxData_i, RxDone_i,
    output TxData_o, Regs_o, WriteStrobe_o, WriteAddr_o, Busy_o, FrameError_o, FrameCount_o
  );

  modport master (
    output CS_i, RxData_i, RxDone_i,
    input  TxData_o, Regs_o, WriteStrobe_o, WriteAddr_o, Busy_o, FrameError_o, FrameCount_o
  );
endinterface

// File: rtl/spi_register_controller.sv
// Decodes CS-framed SPI byte streams into register-bank reads and writes with an
// auto-incrementing, wrapping address; counts frames and flags invalid commands.
module spi_register_controller #(
  parameter int unsigned REG_COUNT = 8,
  parameter logic [7:0]  TX_IDLE   = 8'hA5
) (
  input  logic                    Clock,
  input  logic                    Reset,
  spi_register_controller_if.slave bus
);

  typedef logic [REG_COUNT-1:0][7:0] regs_t;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWrite,
    StRead,
    StIgnore
  } state_e;

  state_e     state_q, state_d;
  logic       cs_q;
  logic [2:0] addr_q, addr_d;
  regs_t      regs_q, regs_d;
  logic [7:0] tx_q, tx_d;
  logic       wstrobe_q, wstrobe_d;
  logic [2:0] waddr_q, waddr_d;
  logic       ferr_q, ferr_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       cmd_valid;
  logic [2:0] addr_next;

  function automatic logic [2:0] addr_inc(input logic [2:0] a);
    return (a == 3'(REG_COUNT - 1)) ? 3'd0 : a + 3'd1;
  endfunction

  // Addresses are 3 bits but the bank may be smaller, so select by compare.
  function automatic logic [7:0] reg_rd(input regs_t r, input logic [2:0] a);
    logic [7:0] v;
    v = '0;
    for (int unsigned k = 0; k < REG_COUNT; k++) begin
      if (a == 3'(k)) v = r[k];
    end
    return v;
  endfunction

  assign cmd_valid = (bus.RxData_i[6:3] == 4'b0000) &&
                     ({1'b0, bus.RxData_i[2:0]} < 4'(REG_COUNT));
  assign addr_next = addr_inc(addr_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    regs_d    = regs_q;
    tx_d      = tx_q;
    wstrobe_d = 1'b0;
    waddr_d   = waddr_q;
    ferr_d    = ferr_q;
    fcnt_d    = fcnt_q;

    unique case (state_q)
      StIdle: begin
        if (cs_q && !bus.CS_i) state_d = StCmd;
      end
      StCmd: begin
        if (bus.RxDone_i) begin
          if (!cmd_valid) begin
            state_d = StIgnore;
            ferr_d  = 1'b1;
          end else if (bus.RxData_i[7]) begin
            state_d = StWrite;
            addr_d  = bus.RxData_i[2:0];
          end else begin
            state_d = StRead;
            addr_d  = bus.RxData_i[2:0];
            tx_d    = reg_rd(regs_q, bus.RxData_i[2:0]);
          end
        end
      end
      StWrite: begin
        if (bus.RxDone_i) begin
          for (int unsigned k = 0; k < REG_COUNT; k++) begin
            if (addr_q == 3'(k)) regs_d[k] = bus.RxData_i;
          end
          wstrobe_d = 1'b1;
          waddr_d   = addr_q;
          addr_d    = addr_next;
        end
      end
      StRead: begin
        if (bus.RxDone_i) begin
          addr_d = addr_next;
          tx_d   = reg_rd(regs_q, addr_next);
        end
      end
      StIgnore: ;
      default: state_d = StIdle;
    endcase

    // Frame end overrides the state but keeps any byte processed in the same cycle.
    if (state_q != StIdle && bus.CS_i) begin
      state_d = StIdle;
      tx_d    = TX_IDLE;
      fcnt_d  = fcnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      cs_q      <= 1'b0;
      addr_q    <= '0;
      regs_q    <= '0;
      tx_q      <= TX_IDLE;
      wstrobe_q <= 1'b0;
      waddr_q   <= '0;
      ferr_q    <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cs_q      <= bus.CS_i;
      addr_q    <= addr_d;
      regs_q    <= regs_d;
      tx_q      <= tx_d;
      wstrobe_q <= wstrobe_d;
      waddr_q   <= waddr_d;
      ferr_q    <= ferr_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign bus.TxData_o      = tx_q;
  assign bus.Regs_o        = regs_q;
  assign bus.WriteStrobe_o = wstrobe_q;
  assign bus.WriteAddr_o   = waddr_q;
  assign bus.Busy_o        = (state_q != StIdle);
  assign bus.FrameError_o  = ferr_q;
  assign bus.FrameCount_o  = fcnt_q;

endmodule
